// File: rtl/ds_pkg.sv
// ds_pkg: shared definitions for the data-stack operation (DSOP) command set.
// Used by the data_stack responder and by the control unit that issues DSOP.
// Contents:
//   DS_NOP..DS_POP2  4-bit operation codes (9..15 are reserved and act as NOP)
//   ds_op_info_t     minimum depth (need) and signed depth change (delta) per op
//   ds_op_info()     lookup from opcode to ds_op_info_t
package ds_pkg;

  localparam logic [3:0] DS_NOP     = 4'd0;
  localparam logic [3:0] DS_PUSH    = 4'd1;
  localparam logic [3:0] DS_POP     = 4'd2;
  localparam logic [3:0] DS_DUP     = 4'd3;
  localparam logic [3:0] DS_SWAP    = 4'd4;
  localparam logic [3:0] DS_OVER    = 4'd5;
  localparam logic [3:0] DS_BINOP   = 4'd6;
  localparam logic [3:0] DS_REPLACE = 4'd7;
  localparam logic [3:0] DS_POP2    = 4'd8;

  typedef struct packed {
    logic [1:0]        need;
    logic signed [2:0] delta;
  } ds_op_info_t;

  function automatic ds_op_info_t ds_op_info(input logic [3:0] op);
    ds_op_info_t r;
    r.need  = 2'd0;
    r.delta = 3'sd0;
    case (op)
      DS_PUSH:    begin r.need = 2'd0; r.delta =  3'sd1; end
      DS_POP:     begin r.need = 2'd1; r.delta = -3'sd1; end
      DS_DUP:     begin r.need = 2'd1; r.delta =  3'sd1; end
      DS_SWAP:    begin r.need = 2'd2; r.delta =  3'sd0; end
      DS_OVER:    begin r.need = 2'd2; r.delta =  3'sd1; end
      DS_BINOP:   begin r.need = 2'd2; r.delta = -3'sd1; end
      DS_REPLACE: begin r.need = 2'd1; r.delta =  3'sd0; end
      DS_POP2:    begin r.need = 2'd2; r.delta = -3'sd2; end
      default:    begin r.need = 2'd0; r.delta =  3'sd0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_stack_if.sv
// data_stack_if: DSOP command interface between control (master) and the
// data stack (slave).
// Master drives: DSOP, ds_data, sr1_overwrite, sr1_in, err_clr.
// Slave drives:  sr0, sr1, ds_depth, ds_empty, ds_full, ds_ovf, ds_unf
//                (+ ds_hwm when DS_HIGH_WATER_EN is defined).
interface data_stack_if #(
  parameter int WIDTH = 16,
  parameter int PTR_W = 5
);
  logic [3:0]       DSOP;
  logic [WIDTH-1:0] ds_data;
  logic             sr1_overwrite;
  logic [WIDTH-1:0] sr1_in;
  logic             err_clr;
  logic [WIDTH-1:0] sr0;
  logic [WIDTH-1:0] sr1;
  logic [PTR_W-1:0] ds_depth;
  logic             ds_empty;
  logic             ds_full;
  logic             ds_ovf;
  logic             ds_unf;
`ifdef DS_HIGH_WATER_EN
  logic [PTR_W-1:0] ds_hwm;

  modport master (
    output DSOP, ds_data, sr1_overwrite, sr1_in, err_clr,
    input  sr0, sr1, ds_depth, ds_empty, ds_full, ds_ovf, ds_unf, ds_hwm
  );
  modport slave (
    input  DSOP, ds_data, sr1_overwrite, sr1_in, err_clr,
    output sr0, sr1, ds_depth, ds_empty, ds_full, ds_ovf, ds_unf, ds_hwm
  );
`else
  modport master (
    output DSOP, ds_data, sr1_overwrite, sr1_in, err_clr,
    input  sr0, sr1, ds_depth, ds_empty, ds_full, ds_ovf, ds_unf
  );
  modport slave (
    input  DSOP, ds_data, sr1_overwrite, sr1_in, err_clr,
    output sr0, sr1, ds_depth, ds_empty, ds_full, ds_ovf, ds_unf
  );
`endif
endinterface

// File: rtl/ds_spill_ram.sv
// ds_spill_ram: backing store for stack entries below sr0/sr1.
// Synchronous write, combinational read at two addresses (top, top-1) so a
// one- or two-entry refill completes in the same cycle as the op.
// Ports: clk; we/wr_addr/wr_data write port; rd_addr_top/rd_addr_top1 read
// addresses; rd_top/rd_top1 read data.
module ds_spill_ram #(
  parameter int WIDTH   = 16,
  parameter int ENTRIES = 14,
  parameter int AW      = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_top,
  input  logic [AW-1:0]    rd_addr_top1,
  output logic [WIDTH-1:0] rd_top,
  output logic [WIDTH-1:0] rd_top1
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_top  = mem[rd_addr_top];
  assign rd_top1 = mem[rd_addr_top1];

endmodule

// File: rtl/data_stack.sv
// data_stack: responder for DSOP commands. Executes one stack op per clock;
// the top two entries are held in registers (sr0, sr1) and deeper entries
// spill into ds_spill_ram. Ops that would overflow or underflow are
// suppressed (including any same-cycle sr1_overwrite) and set sticky flags.
// Ports: clk; async_reset (synchronous, active-high); ds (data_stack_if.slave)
// carrying DSOP/ds_data/sr1_overwrite/sr1_in/err_clr in and
// sr0/sr1/ds_depth/ds_empty/ds_full/ds_ovf/ds_unf out.
// Optional macro DS_HIGH_WATER_EN adds ds_hwm, the peak depth since reset
// (err_clr reloads it with the current depth).
module data_stack
  import ds_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTR_W = 5
) (
  input  logic         clk,
  input  logic         async_reset,
  data_stack_if.slave  ds
);

  localparam int ENTRIES = DEPTH - 2;
  localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int DW      = PTR_W + 2;

  logic [WIDTH-1:0] sr0_p1, sr1_p1;
  logic [PTR_W-1:0] depth_p1;
  logic             ovf_p1, unf_p1;

  ds_op_info_t       info;
  logic signed [DW-1:0] depth_s, depth_nxt_s;
  logic [PTR_W-1:0]  depth_nxt;
  logic              ovf_evt, unf_evt, suppress, spill;
  logic [WIDTH-1:0]  sr0_nxt, sr1_nxt, ram_top, ram_top1;
  logic [WIDTH-1:0]  rd_top, rd_top1;
  logic              ram_we;

  ds_spill_ram #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .AW(AW)) u_ram (
    .clk          (clk),
    .we           (ram_we),
    .wr_addr      (AW'(depth_p1 - PTR_W'(2))),
    .wr_data      (sr1_p1),
    .rd_addr_top  (AW'(depth_p1 - PTR_W'(3))),
    .rd_addr_top1 (AW'(depth_p1 - PTR_W'(4))),
    .rd_top       (rd_top),
    .rd_top1      (rd_top1)
  );

  always_comb begin
    info        = ds_op_info(ds.DSOP);
    depth_s     = signed'({2'b00, depth_p1});
    depth_nxt_s = depth_s + DW'(info.delta);
    unf_evt     = {1'b0, depth_p1} < (PTR_W+1)'(info.need);
    ovf_evt     = (info.delta > 3'sd0) && (depth_nxt_s > DW'(DEPTH));
    suppress    = ovf_evt | unf_evt;
    depth_nxt   = PTR_W'(depth_nxt_s);

    // RAM slots only hold live data when depth exceeds the register pair
    ram_top  = (depth_p1 >= PTR_W'(3)) ? rd_top  : '0;
    ram_top1 = (depth_p1 >= PTR_W'(4)) ? rd_top1 : '0;

    sr0_nxt = sr0_p1;
    sr1_nxt = sr1_p1;
    spill   = 1'b0;
    case (ds.DSOP)
      DS_PUSH:    begin sr0_nxt = ds.ds_data; sr1_nxt = sr0_p1;  spill = 1'b1; end
      DS_POP:     begin sr0_nxt = sr1_p1;     sr1_nxt = ram_top;               end
      DS_DUP:     begin sr0_nxt = sr0_p1;     sr1_nxt = sr0_p1;  spill = 1'b1; end
      DS_SWAP:    begin sr0_nxt = sr1_p1;     sr1_nxt = sr0_p1;                end
      DS_OVER:    begin sr0_nxt = sr1_p1;     sr1_nxt = sr0_p1;  spill = 1'b1; end
      DS_BINOP:   begin sr0_nxt = ds.ds_data; sr1_nxt = ram_top;               end
      DS_REPLACE: begin sr0_nxt = ds.ds_data;                                  end
      DS_POP2:    begin sr0_nxt = ram_top;    sr1_nxt = ram_top1;              end
      default:    ;
    endcase

    // Registers with no backing entry read as zero
    if (depth_nxt < PTR_W'(1)) sr0_nxt = '0;
    if (depth_nxt < PTR_W'(2)) sr1_nxt = '0;
    else if (ds.sr1_overwrite) sr1_nxt = ds.sr1_in;

    ram_we = !async_reset && !suppress && spill && (depth_p1 >= PTR_W'(2));
  end

  // Stage p1: registered stack state and sticky flags (set beats clear)
  always_ff @(posedge clk) begin
    if (async_reset) begin
      sr0_p1   <= '0;
      sr1_p1   <= '0;
      depth_p1 <= '0;
      ovf_p1   <= 1'b0;
      unf_p1   <= 1'b0;
    end else begin
      if (!suppress) begin
        sr0_p1   <= sr0_nxt;
        sr1_p1   <= sr1_nxt;
        depth_p1 <= depth_nxt;
      end
      ovf_p1 <= ovf_evt | (ovf_p1 & ~ds.err_clr);
      unf_p1 <= unf_evt | (unf_p1 & ~ds.err_clr);
    end
  end

  assign ds.sr0      = sr0_p1;
  assign ds.sr1      = sr1_p1;
  assign ds.ds_depth = depth_p1;
  assign ds.ds_empty = (depth_p1 == '0);
  assign ds.ds_full  = (depth_p1 == PTR_W'(DEPTH));
  assign ds.ds_ovf   = ovf_p1;
  assign ds.ds_unf   = unf_p1;

`ifdef DS_HIGH_WATER_EN
  logic [PTR_W-1:0] hwm_p1;

  // Stage p1: peak tracker follows the registered depth one cycle later
  always_ff @(posedge clk) begin
    if (async_reset)             hwm_p1 <= '0;
    else if (ds.err_clr)         hwm_p1 <= depth_p1;
    else if (depth_p1 > hwm_p1)  hwm_p1 <= depth_p1;
  end

  assign ds.ds_hwm = hwm_p1;
`endif

endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack: self-checking bench for data_stack. A vector table is
// driven one op per cycle with expected results queued as each op is
// applied; hand-written sequences cover fill/overflow/drain and reset.
module tb_data_stack;
  import ds_pkg::*;

  logic clk = 1'b0;
  logic async_reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  data_stack_if #(.WIDTH(16), .PTR_W(5)) dif ();

  data_stack #(.WIDTH(16), .DEPTH(16), .PTR_W(5)) dut (
    .clk         (clk),
    .async_reset (async_reset),
    .ds          (dif)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] data;
    logic        ovr;
    logic [15:0] s1in;
    logic        clr;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [4:0]  ed;
    logic        eo;
    logic        eu;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] data,
                              input logic ovr, input logic [15:0] s1in,
                              input logic clr, input logic [15:0] e0,
                              input logic [15:0] e1, input logic [4:0] ed,
                              input logic eo, input logic eu);
    vec_t v;
    v.op = op; v.data = data; v.ovr = ovr; v.s1in = s1in; v.clr = clr;
    v.e0 = e0; v.e1 = e1; v.ed = ed; v.eo = eo; v.eu = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] data,
                       input logic ovr, input logic [15:0] s1in, input logic clr);
    dif.DSOP          = op;
    dif.ds_data       = data;
    dif.sr1_overwrite = ovr;
    dif.sr1_in        = s1in;
    dif.err_clr       = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t e;

    // op, data, ovr, s1in, clr -> sr0, sr1, depth, ovf, unf
    vecs.push_back(mk(DS_PUSH,    16'h0011, 0, 0,        0, 16'h0011, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(DS_PUSH,    16'h0022, 0, 0,        0, 16'h0022, 16'h0011, 2, 0, 0));
    vecs.push_back(mk(DS_PUSH,    16'h0033, 0, 0,        0, 16'h0033, 16'h0022, 3, 0, 0));
    vecs.push_back(mk(DS_POP2,    16'h0000, 0, 0,        0, 16'h0011, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(DS_POP,     16'h0000, 0, 0,        0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(DS_PUSH,    16'h0007, 0, 0,        0, 16'h0007, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(DS_PUSH,    16'h0005, 0, 0,        0, 16'h0005, 16'h0007, 2, 0, 0));
    vecs.push_back(mk(DS_SWAP,    16'h0000, 0, 0,        0, 16'h0007, 16'h0005, 2, 0, 0));
    vecs.push_back(mk(DS_OVER,    16'h0000, 0, 0,        0, 16'h0005, 16'h0007, 3, 0, 0));
    vecs.push_back(mk(DS_BINOP,   16'h000C, 0, 0,        0, 16'h000C, 16'h0005, 2, 0, 0));
    vecs.push_back(mk(DS_REPLACE, 16'h0044, 0, 0,        0, 16'h0044, 16'h0005, 2, 0, 0));
    vecs.push_back(mk(DS_NOP,     16'h0000, 1, 16'h00AA, 0, 16'h0044, 16'h00AA, 2, 0, 0));
    vecs.push_back(mk(4'd9,       16'h1111, 0, 0,        0, 16'h0044, 16'h00AA, 2, 0, 0));
    vecs.push_back(mk(DS_POP,     16'h0000, 0, 0,        0, 16'h00AA, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(DS_POP,     16'h0000, 0, 0,        0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(DS_POP,     16'h0000, 0, 0,        1, 16'h0000, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(DS_NOP,     16'h0000, 0, 0,        1, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(DS_PUSH,    16'h0003, 0, 0,        0, 16'h0003, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(DS_DUP,     16'h0000, 1, 16'hBEEF, 0, 16'h0003, 16'hBEEF, 2, 0, 0));
    vecs.push_back(mk(DS_POP,     16'h0000, 0, 0,        0, 16'hBEEF, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(DS_POP,     16'h0000, 0, 0,        0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(DS_NOP,     16'h0000, 1, 16'h1234, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(DS_SWAP,    16'h0000, 1, 16'h5678, 0, 16'h0000, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(DS_NOP,     16'h0000, 0, 0,        1, 16'h0000, 16'h0000, 0, 0, 0));

    async_reset = 1'b1;
    drive(DS_NOP, 0, 0, 0, 0);
    step();
    step();
    async_reset = 1'b0;
    chk("rst sr0",   dif.sr0, 0);
    chk("rst sr1",   dif.sr1, 0);
    chk("rst depth", dif.ds_depth, 0);
    chk("rst empty", dif.ds_empty, 1);
    chk("rst full",  dif.ds_full, 0);
    chk("rst ovf",   dif.ds_ovf, 0);
    chk("rst unf",   dif.ds_unf, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].data, vecs[i].ovr, vecs[i].s1in, vecs[i].clr);
      sb.push_back(vecs[i]);
      step();
      e = sb.pop_front();
      chk($sformatf("v%0d sr0", i),   dif.sr0, e.e0);
      chk($sformatf("v%0d sr1", i),   dif.sr1, e.e1);
      chk($sformatf("v%0d depth", i), dif.ds_depth, e.ed);
      chk($sformatf("v%0d empty", i), dif.ds_empty, (e.ed == 0));
      chk($sformatf("v%0d ovf", i),   dif.ds_ovf, e.eo);
      chk($sformatf("v%0d unf", i),   dif.ds_unf, e.eu);
    end

    // Fill to capacity, then one push too many (overwrite must also be dropped)
    for (int k = 1; k <= 16; k++) begin
      drive(DS_PUSH, 16'(k), 0, 0, 0);
      step();
      chk($sformatf("fill%0d depth", k), dif.ds_depth, k);
    end
    chk("fill full", dif.ds_full, 1);
    drive(DS_PUSH, 16'hFFFF, 1, 16'hDEAD, 0);
    step();
    chk("ovf flag",  dif.ds_ovf, 1);
    chk("ovf full",  dif.ds_full, 1);
    chk("ovf sr0",   dif.sr0, 16);
    chk("ovf sr1",   dif.sr1, 15);
    chk("ovf depth", dif.ds_depth, 16);
`ifdef DS_HIGH_WATER_EN
    chk("hwm peak", dif.ds_hwm, 16);
`endif
    drive(DS_NOP, 0, 0, 0, 1);
    step();
    chk("ovf clr", dif.ds_ovf, 0);

    // Drain: every entry comes back in LIFO order via RAM refills
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d sr0", k), dif.sr0, 16 - k);
      drive(DS_POP, 0, 0, 0, 0);
      step();
    end
    chk("drain empty", dif.ds_empty, 1);
    chk("drain depth", dif.ds_depth, 0);
    chk("drain sr0",   dif.sr0, 0);
    chk("drain unf",   dif.ds_unf, 0);

    // Reset during a PUSH at depth 4, with a sticky underflow pending
    drive(DS_POP, 0, 0, 0, 0);
    step();
    chk("pre unf", dif.ds_unf, 1);
    for (int k = 0; k < 4; k++) begin
      drive(DS_PUSH, 16'hA1 + 16'(k), 0, 0, 0);
      step();
    end
    chk("pre depth", dif.ds_depth, 4);
    drive(DS_PUSH, 16'h0099, 0, 0, 0);
    async_reset = 1'b1;
    step();
    async_reset = 1'b0;
    chk("mrst sr0",   dif.sr0, 0);
    chk("mrst sr1",   dif.sr1, 0);
    chk("mrst depth", dif.ds_depth, 0);
    chk("mrst empty", dif.ds_empty, 1);
    chk("mrst full",  dif.ds_full, 0);
    chk("mrst ovf",   dif.ds_ovf, 0);
    chk("mrst unf",   dif.ds_unf, 0);
`ifdef DS_HIGH_WATER_EN
    chk("mrst hwm",   dif.ds_hwm, 0);
`endif
    drive(DS_NOP, 0, 0, 0, 0);
    step();
    chk("post depth", dif.ds_depth, 0);
    chk("post sr0",   dif.sr0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
